// File: rtl/axi_bridge_pkg.sv
// Shared constants and FSM encodings for the SRAM-to-AXI3 bridge.
// Both the read path (top) and the write controller import this package.
package axi_bridge_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] ID_INST    = 4'd0;
    localparam logic [3:0] ID_DATA    = 4'd1;
    localparam logic [3:0] ID_WR      = 4'd1;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_R = 2'd2} rd_state_e;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_B = 2'd2} wr_state_e;

    // Read-after-write hazards are tracked at word granularity.
    function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

endpackage

// File: rtl/sram_axi_bridge_if.sv
// AXI3 master bus leaving the CPU top. Handshakes: a transfer happens in the
// cycle where valid and ready are both 1; valid never waits on ready.
interface sram_axi_bridge_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/bridge_wr_ctrl.sv
// AW/W/B sequencer for data-port writes. Holds the latched write address so
// the top can block reads that hit the word currently being written.
module bridge_wr_ctrl
    import axi_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    input  logic        awready,
    input  logic        wready,
    input  logic        bvalid,
    output logic        awvalid,
    output logic        wvalid,
    output logic        bready,
    output logic        busy,
    output logic [31:0] waddr,
    output logic [1:0]  wsize,
    output logic [3:0]  wstrb_q,
    output logic [31:0] wdata_q,
    output wr_state_e   state
);
    wr_state_e w_state, w_next;
    logic      aw_pend, w_pend;
    logic      aw_done, w_done;

    // AW and W complete independently; each side counts as done once its
    // pending flag has cleared or it handshakes this cycle.
    assign aw_done = ~aw_pend | awready;
    assign w_done  = ~w_pend  | wready;

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (start) w_next = W_REQ;
            W_REQ:   if (aw_done && w_done) w_next = W_B;
            W_B:     if (bvalid) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state <= W_IDLE;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            waddr   <= '0;
            wsize   <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
        end else begin
            w_state <= w_next;
            if (w_state == W_IDLE && start) begin
                aw_pend <= 1'b1;
                w_pend  <= 1'b1;
                waddr   <= addr;
                wsize   <= size;
                wstrb_q <= wstrb;
                wdata_q <= wdata;
            end else begin
                if (awvalid && awready) aw_pend <= 1'b0;
                if (wvalid && wready)   w_pend  <= 1'b0;
            end
        end
    end

    assign awvalid = (w_state == W_REQ) & aw_pend;
    assign wvalid  = (w_state == W_REQ) & w_pend;
    assign bready  = (w_state == W_B);
    assign busy    = (w_state != W_IDLE);
    assign state   = w_state;
endmodule

// File: rtl/sram_axi_bridge.sv
// Merges the core's inst/data SRAM-like ports onto one AXI3 master. Reads share
// a single outstanding AR/R slot (data beats inst); data writes go to bridge_wr_ctrl.
module sram_axi_bridge
    import axi_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    sram_axi_bridge_if.master axi,
    output rd_state_e   rd_state_dbg,
    output wr_state_e   wr_state_dbg
);
    rd_state_e   r_state, r_next;
    logic [3:0]  ar_id_q;
    logic [31:0] ar_addr_q;
    logic [1:0]  ar_size_q;
    logic        data_busy;
    logic        wr_busy, wr_awvalid, wr_wvalid, wr_bready;
    logic [31:0] wr_addr, wr_data;
    logic [1:0]  wr_size;
    logic [3:0]  wr_strb;
    logic        data_rd_ok, data_wr_ok, inst_rd_ok, rd_accept, r_hs;

    // Data read only wins arbitration when it can actually be accepted, so a
    // blocked data read never starves an eligible inst read.
    assign data_rd_ok = data_sram_req & ~data_sram_wr & ~data_busy & (r_state == R_IDLE)
                      & ~(wr_busy & same_word(wr_addr, data_sram_addr));
    assign data_wr_ok = data_sram_req & data_sram_wr & ~data_busy & ~wr_busy;
    assign inst_rd_ok = inst_sram_req & (r_state == R_IDLE) & ~data_rd_ok
                      & ~(wr_busy & same_word(wr_addr, inst_sram_addr));
    assign rd_accept  = data_rd_ok | inst_rd_ok;

    assign inst_sram_addr_ok = inst_rd_ok;
    assign data_sram_addr_ok = data_rd_ok | data_wr_ok;

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (rd_accept) r_next = R_AR;
            R_AR:    if (axi.arready) r_next = R_R;
            R_R:     if (axi.rvalid && axi.rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= R_IDLE;
            ar_id_q   <= '0;
            ar_addr_q <= '0;
            ar_size_q <= '0;
        end else begin
            r_state <= r_next;
            if (r_state == R_IDLE && rd_accept) begin
                ar_id_q   <= data_rd_ok ? ID_DATA : ID_INST;
                ar_addr_q <= data_rd_ok ? data_sram_addr : inst_sram_addr;
                ar_size_q <= data_rd_ok ? data_sram_size : inst_sram_size;
            end
        end
    end

    // One data-port transaction in flight: set on accept, cleared by its data_ok.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                data_busy <= 1'b0;
        else if (data_sram_addr_ok) data_busy <= 1'b1;
        else if (data_sram_data_ok) data_busy <= 1'b0;
    end

    bridge_wr_ctrl u_wr_ctrl (
        .clk     (clk),
        .resetn  (resetn),
        .start   (data_wr_ok),
        .addr    (data_sram_addr),
        .size    (data_sram_size),
        .wstrb   (data_sram_wstrb),
        .wdata   (data_sram_wdata),
        .awready (axi.awready),
        .wready  (axi.wready),
        .bvalid  (axi.bvalid),
        .awvalid (wr_awvalid),
        .wvalid  (wr_wvalid),
        .bready  (wr_bready),
        .busy    (wr_busy),
        .waddr   (wr_addr),
        .wsize   (wr_size),
        .wstrb_q (wr_strb),
        .wdata_q (wr_data),
        .state   (wr_state_dbg)
    );

    assign axi.arid    = ar_id_q;
    assign axi.araddr  = ar_addr_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = {1'b0, ar_size_q};
    assign axi.arburst = BURST_INCR;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.arvalid = (r_state == R_AR);
    assign axi.rready  = (r_state == R_R);

    assign axi.awid    = ID_WR;
    assign axi.awaddr  = wr_addr;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = {1'b0, wr_size};
    assign axi.awburst = BURST_INCR;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
    assign axi.awvalid = wr_awvalid;
    assign axi.wid     = ID_WR;
    assign axi.wdata   = wr_data;
    assign axi.wstrb   = wr_strb;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wr_wvalid;
    assign axi.bready  = wr_bready;

    assign r_hs              = axi.rvalid & axi.rready;
    assign inst_sram_data_ok = r_hs & (axi.rid == ID_INST);
    assign data_sram_data_ok = (r_hs & (axi.rid == ID_DATA)) | (axi.bvalid & axi.bready);
    assign inst_sram_rdata   = axi.rdata;
    assign data_sram_rdata   = axi.rdata;
    assign rd_state_dbg      = r_state;

    logic unused_ok;
    assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                         axi.rresp, axi.bresp, axi.bid};
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: main thread drives SRAM requests and the
// AXI slave side; a negedge monitor checks every data_ok against expected queues.
module tb_sram_axi_bridge;
    import axi_bridge_pkg::*;

    logic        clk, resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    rd_state_e   rd_state_dbg;
    wr_state_e   wr_state_dbg;

    sram_axi_bridge_if axi ();

    sram_axi_bridge dut (
        .clk               (clk),
        .resetn            (resetn),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .axi               (axi),
        .rd_state_dbg      (rd_state_dbg),
        .wr_state_dbg      (wr_state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [31:0] inst_exp_q[$];
    logic [32:0] data_exp_q[$];   // {is_write, rdata}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // driver tasks
    task automatic set_inst(input logic req, input logic [31:0] addr);
        inst_sram_req  = req;
        inst_sram_addr = addr;
        inst_sram_size = 2'd2;
    endtask

    task automatic set_data(input logic req, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata);
        data_sram_req   = req;
        data_sram_wr    = wr;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        data_sram_size  = 2'd2;
        data_sram_wstrb = 4'hF;
    endtask

    task automatic r_beat(input logic v, input logic [3:0] id, input logic [31:0] d);
        axi.rvalid = v;
        axi.rid    = id;
        axi.rdata  = d;
        axi.rlast  = v;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (resetn) begin
            if (inst_sram_data_ok) begin
                if (inst_exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL inst_unexpected_data_ok: got data_ok=1 expected no response");
                end else begin
                    chk("inst_rdata", inst_sram_rdata, inst_exp_q.pop_front());
                end
            end
            if (data_sram_data_ok) begin
                if (data_exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL data_unexpected_data_ok: got data_ok=1 expected no response");
                end else begin
                    logic [32:0] e;
                    e = data_exp_q.pop_front();
                    chk("data_resp_kind", {31'b0, axi.bvalid}, {31'b0, e[32]});
                    if (!e[32]) chk("data_rdata", data_sram_rdata, e[31:0]);
                end
            end
        end
    end

    initial begin
        resetn = 1'b0;
        inst_sram_wr = 1'b0; inst_sram_wstrb = 4'h0; inst_sram_wdata = 32'h0;
        set_inst(1'b0, 32'h0);
        set_data(1'b0, 1'b0, 32'h0, 32'h0);
        axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
        axi.rresp = 2'b00; axi.bresp = 2'b00; axi.bid = 4'd1; axi.bvalid = 1'b0;
        r_beat(1'b0, 4'd0, 32'h0);

        // reset state
        repeat (2) smp();
        chk("rst_arvalid", {31'b0, axi.arvalid}, 32'd0);
        chk("rst_awvalid", {31'b0, axi.awvalid}, 32'd0);
        chk("rst_wvalid",  {31'b0, axi.wvalid},  32'd0);
        chk("rst_rready",  {31'b0, axi.rready},  32'd0);
        chk("rst_bready",  {31'b0, axi.bready},  32'd0);
        chk("rst_addr_ok", {30'b0, inst_sram_addr_ok, data_sram_addr_ok}, 32'd0);
        chk("rst_data_ok", {30'b0, inst_sram_data_ok, data_sram_data_ok}, 32'd0);
        chk("rst_states",  {28'b0, rd_state_dbg, wr_state_dbg}, {28'b0, R_IDLE, W_IDLE});
        chk("rst_araddr",  axi.araddr, 32'h0);
        tick();
        resetn = 1'b1;

        // inst read, minimum latency
        tick();
        set_inst(1'b1, 32'h1C000000);
        smp();
        chk("t1_inst_addr_ok", {31'b0, inst_sram_addr_ok}, 32'd1);
        inst_exp_q.push_back(32'h12345678);
        tick();
        set_inst(1'b0, 32'h0);
        axi.arready = 1'b1;
        smp();
        chk("t1_arvalid", {31'b0, axi.arvalid}, 32'd1);
        chk("t1_araddr",  axi.araddr, 32'h1C000000);
        chk("t1_arid",    {28'b0, axi.arid}, 32'd0);
        chk("t1_ar_fields", {axi.arlen, 5'b0, axi.arsize, 6'b0, axi.arburst, axi.arlock,
                             axi.arcache, 1'b0, axi.arprot}, {8'd0, 5'b0, 3'd2, 6'b0, 2'b01, 2'b00, 4'd0, 1'b0, 3'd0});
        tick();
        axi.arready = 1'b0;
        r_beat(1'b1, 4'd0, 32'h12345678);
        smp();
        chk("t1_rready",    {31'b0, axi.rready}, 32'd1);
        chk("t1_data_ok_c2", {31'b0, inst_sram_data_ok}, 32'd1);
        tick();
        r_beat(1'b0, 4'd0, 32'h0);
        smp();
        chk("t1_data_ok_pulse", {31'b0, inst_sram_data_ok}, 32'd0);
        chk("t1_rd_idle", {30'b0, rd_state_dbg}, {30'b0, R_IDLE});

        // simultaneous inst and data reads: data wins
        tick();
        set_inst(1'b1, 32'h00000100);
        set_data(1'b1, 1'b0, 32'h00000200, 32'h0);
        smp();
        chk("t2_arb", {30'b0, data_sram_addr_ok, inst_sram_addr_ok}, 32'b10);
        data_exp_q.push_back({1'b0, 32'hDEAD0001});
        tick();
        set_data(1'b0, 1'b0, 32'h0, 32'h0);
        axi.arready = 1'b1;
        smp();
        chk("t2_arid_data", {28'b0, axi.arid}, 32'd1);
        chk("t2_araddr",    axi.araddr, 32'h00000200);
        chk("t2_inst_wait", {31'b0, inst_sram_addr_ok}, 32'd0);
        tick();
        axi.arready = 1'b0;
        r_beat(1'b1, 4'd1, 32'hDEAD0001);
        smp();
        chk("t2_inst_wait_r", {31'b0, inst_sram_addr_ok}, 32'd0);
        tick();
        r_beat(1'b0, 4'd0, 32'h0);
        smp();
        chk("t2_inst_retry_ok", {31'b0, inst_sram_addr_ok}, 32'd1);
        inst_exp_q.push_back(32'hCAFE0002);
        tick();
        set_inst(1'b0, 32'h0);
        axi.arready = 1'b1;
        smp();
        chk("t2_arid_inst", {28'b0, axi.arid}, 32'd0);
        chk("t2_araddr_inst", axi.araddr, 32'h00000100);
        tick();
        axi.arready = 1'b0;
        r_beat(1'b1, 4'd0, 32'hCAFE0002);
        tick();
        r_beat(1'b0, 4'd0, 32'h0);

        // data write, awready two cycles before wready, plus RAW hazard on 0x80
        set_data(1'b1, 1'b1, 32'h00000080, 32'hA5A5A5A5);
        smp();
        chk("t3_wr_addr_ok", {31'b0, data_sram_addr_ok}, 32'd1);
        data_exp_q.push_back({1'b1, 32'h0});
        tick();
        set_data(1'b0, 1'b0, 32'h0, 32'h0);
        axi.awready = 1'b1;
        smp();
        chk("t3_aw_w_valid", {30'b0, axi.awvalid, axi.wvalid}, 32'b11);
        chk("t3_awaddr",  axi.awaddr, 32'h00000080);
        chk("t3_wdata",   axi.wdata, 32'hA5A5A5A5);
        chk("t3_w_fields", {axi.awid, axi.wid, axi.wstrb, 1'b0, axi.awsize, 7'b0, axi.wlast, 8'b0, axi.awlen},
                           {4'd1, 4'd1, 4'hF, 1'b0, 3'd2, 7'b0, 1'b1, 8'b0, 8'd0});
        tick();
        axi.awready = 1'b0;
        smp();
        chk("t3_aw_dropped", {30'b0, axi.awvalid, axi.wvalid}, 32'b01);
        tick();
        axi.wready = 1'b1;
        smp();
        chk("t3_w_held", {30'b0, axi.awvalid, axi.wvalid}, 32'b01);
        tick();
        axi.wready = 1'b0;
        set_inst(1'b1, 32'h00000080);
        smp();
        chk("t3_bready", {30'b0, axi.bready, axi.wvalid}, 32'b10);
        chk("t4_hazard_block", {31'b0, inst_sram_addr_ok}, 32'd0);
        tick();
        axi.bvalid = 1'b1;
        smp();
        chk("t4_hazard_bvalid", {31'b0, inst_sram_addr_ok}, 32'd0);
        tick();
        axi.bvalid = 1'b0;
        smp();
        chk("t4_hazard_clear", {31'b0, inst_sram_addr_ok}, 32'd1);
        inst_exp_q.push_back(32'h11110080);
        tick();
        set_inst(1'b0, 32'h0);
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        r_beat(1'b1, 4'd0, 32'h11110080);
        tick();
        r_beat(1'b0, 4'd0, 32'h0);

        // write outstanding: non-hazard inst read proceeds, data read waits
        set_data(1'b1, 1'b1, 32'h00000080, 32'h5A5A5A5A);
        smp();
        chk("t5_wr_addr_ok", {31'b0, data_sram_addr_ok}, 32'd1);
        data_exp_q.push_back({1'b1, 32'h0});
        tick();
        set_data(1'b0, 1'b0, 32'h0, 32'h0);
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        tick();
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        set_inst(1'b1, 32'h00000084);
        set_data(1'b1, 1'b0, 32'h00000300, 32'h0);
        smp();
        chk("t5_w_b_state", {30'b0, wr_state_dbg}, {30'b0, W_B});
        chk("t4_no_hazard_84", {31'b0, inst_sram_addr_ok}, 32'd1);
        chk("t5_data_busy", {31'b0, data_sram_addr_ok}, 32'd0);
        inst_exp_q.push_back(32'h22220084);
        tick();
        set_inst(1'b0, 32'h0);
        axi.arready = 1'b1;
        smp();
        chk("t5_data_busy2", {31'b0, data_sram_addr_ok}, 32'd0);
        tick();
        axi.arready = 1'b0;
        r_beat(1'b1, 4'd0, 32'h22220084);
        axi.bvalid = 1'b1;
        tick();
        r_beat(1'b0, 4'd0, 32'h0);
        axi.bvalid = 1'b0;
        smp();
        chk("t5_data_rd_ok", {31'b0, data_sram_addr_ok}, 32'd1);
        data_exp_q.push_back({1'b0, 32'h33330300});
        tick();
        set_data(1'b0, 1'b0, 32'h0, 32'h0);
        axi.arready = 1'b1;
        smp();
        chk("t5_arid", {28'b0, axi.arid}, 32'd1);
        chk("t5_araddr", axi.araddr, 32'h00000300);
        tick();
        axi.arready = 1'b0;
        r_beat(1'b1, 4'd1, 32'h33330300);
        tick();
        r_beat(1'b0, 4'd0, 32'h0);

        // reset while arvalid is high
        set_inst(1'b1, 32'h00000400);
        smp();
        chk("t6_accept", {31'b0, inst_sram_addr_ok}, 32'd1);
        tick();
        set_inst(1'b0, 32'h0);
        smp();
        chk("t6_arvalid_pre", {31'b0, axi.arvalid}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("t6_arvalid_async", {31'b0, axi.arvalid}, 32'd0);
        chk("t6_rd_idle", {30'b0, rd_state_dbg}, {30'b0, R_IDLE});
        tick();
        tick();
        resetn = 1'b1;
        set_inst(1'b1, 32'h00000500);
        smp();
        chk("t6_post_accept", {31'b0, inst_sram_addr_ok}, 32'd1);
        inst_exp_q.push_back(32'h55550500);
        tick();
        set_inst(1'b0, 32'h0);
        axi.arready = 1'b1;
        smp();
        chk("t6_araddr", axi.araddr, 32'h00000500);
        tick();
        axi.arready = 1'b0;
        r_beat(1'b1, 4'd0, 32'h55550500);
        tick();
        r_beat(1'b0, 4'd0, 32'h0);
        repeat (2) smp();

        // final report
        chk("inst_q_drained", inst_exp_q.size(), 32'd0);
        chk("data_q_drained", data_exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
